// File: rtl/server_auth_responder.sv
// server_auth_responder: checks a request ID against an authorized-ID table, grants/denies, dispatches one op, waits for completion with timeout and failure lockout
// Ports: cfg_we/cfg_idx/cfg_id/cfg_valid write one table entry; unlock leaves LOCKED;
//        start/frame carry a request; auth_done/auth_fail answer it two cycles later;
//        op_start/op_code/data dispatch a granted op; op_done/op_timeout end it;
//        busy is high outside IDLE/LOCKED; locked is high in LOCKED.
module server_auth_responder #(
  parameter int NUM_IDS = 4,
  parameter int MAX_FAILS = 3,
  parameter int OP_TIMEOUT = 255,
  localparam int IW = $clog2(NUM_IDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic [6:0]    cfg_id,
  input  logic          cfg_valid,
  input  logic          unlock,
  input  logic          start,
  input  logic [15:0]   frame,
  output logic          auth_done,
  output logic          auth_fail,
  output logic          op_start,
  output logic [1:0]    op_code,
  output logic [7:0]    data,
  input  logic          op_done,
  output logic          op_timeout,
  output logic          busy,
  output logic          locked
);
  typedef enum logic [2:0] {IDLE, CHECK, GRANT, WAIT_OP, DENY, LOCKED} state_t;
  state_t                   state_q, state_d;
  logic [NUM_IDS-1:0][6:0]  ids_q, ids_d;
  logic [NUM_IDS-1:0]       vld_q, vld_d;
  logic [15:0]              frm_q, frm_d;
  logic [1:0]               opc_q, opc_d;
  logic [7:0]               dat_q, dat_d;
  logic [3:0]               fail_q, fail_d;
  logic [15:0]              tmr_q, tmr_d;
  logic [1:0]               lk_q, lk_d;
  logic                     hit;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ids_q   <= '0;
      vld_q   <= '0;
      frm_q   <= '0;
      opc_q   <= '0;
      dat_q   <= '0;
      fail_q  <= '0;
      tmr_q   <= '0;
      lk_q    <= '0;
    end else begin
      state_q <= state_d;
      ids_q   <= ids_d;
      vld_q   <= vld_d;
      frm_q   <= frm_d;
      opc_q   <= opc_d;
      dat_q   <= dat_d;
      fail_q  <= fail_d;
      tmr_q   <= tmr_d;
      lk_q    <= lk_d;
    end
  end
  always_comb begin
    ids_d = ids_q;
    vld_d = vld_q;
    if (cfg_we) begin
      ids_d[cfg_idx] = cfg_id;
      vld_d[cfg_idx] = cfg_valid;
    end
  end
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_IDS; i++) hit = hit | (vld_q[i] & (ids_q[i] == frm_q[15:9]));
  end
  // lk_q delays a locked-out start by two cycles so its auth_fail lands where a checked deny would
  always_comb begin
    state_d = state_q;
    frm_d   = frm_q;
    opc_d   = opc_q;
    dat_d   = dat_q;
    fail_d  = fail_q;
    tmr_d   = tmr_q;
    lk_d    = {lk_q[0], 1'b0};
    case (state_q)
      IDLE: if (start) begin
        frm_d   = frame;
        state_d = CHECK;
      end
      CHECK: if (hit) begin
        opc_d   = frm_q[8:7];
        dat_d   = {1'b0, frm_q[6:0]};
        state_d = GRANT;
      end else state_d = DENY;
      GRANT: begin
        fail_d  = '0;
        tmr_d   = 16'd1;
        state_d = WAIT_OP;
      end
      WAIT_OP: if (op_done || tmr_q == 16'(OP_TIMEOUT)) state_d = IDLE;
               else tmr_d = tmr_q + 16'd1;
      DENY: begin
        fail_d  = fail_q + 4'd1;
        state_d = (fail_q + 4'd1 == 4'(MAX_FAILS)) ? LOCKED : IDLE;
      end
      LOCKED: if (unlock) begin
        fail_d  = '0;
        state_d = IDLE;
      end else if (start) lk_d[0] = 1'b1;
      default: state_d = IDLE;
    endcase
  end
  assign auth_done  = state_q == GRANT;
  assign op_start   = state_q == GRANT;
  assign auth_fail  = (state_q == DENY) | lk_q[1];
  assign op_timeout = (state_q == WAIT_OP) && (tmr_q == 16'(OP_TIMEOUT)) && !op_done;
  assign busy       = (state_q != IDLE) && (state_q != LOCKED);
  assign locked     = state_q == LOCKED;
  assign op_code    = opc_q;
  assign data       = dat_q;
endmodule

// File: tb/tb_server_auth_responder.sv
// tb_server_auth_responder: directed test with a cycle-indexed expectation schedule for server_auth_responder
module tb_server_auth_responder;
  localparam int N = 1000;
  localparam int TO = 8;
  logic clk = 0, rst_n = 0, cfg_we = 0, cfg_valid = 0, unlock = 0, start = 0, op_done = 0;
  logic [1:0] cfg_idx = 0;
  logic [6:0] cfg_id = 0;
  logic [15:0] frame = 0;
  logic auth_done, auth_fail, op_start, op_timeout, busy, locked;
  logic [1:0] op_code;
  logic [7:0] data;
  int n_chk = 0, n_fail = 0, cyc = 0;
  bit e_busy[N], e_lock[N], e_done[N], e_fail[N], e_to[N];
  bit [1:0] e_opc[N];
  bit [7:0] e_dat[N];
  bit [6:0] m_id[4];
  bit m_vld[4];
  int fails = 0, win_g = 0, mn = 0;
  bit win_act = 0, mhit = 0;
  server_auth_responder #(.NUM_IDS(4), .MAX_FAILS(3), .OP_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_id(cfg_id),
    .cfg_valid(cfg_valid), .unlock(unlock), .start(start), .frame(frame),
    .auth_done(auth_done), .auth_fail(auth_fail), .op_start(op_start), .op_code(op_code),
    .data(data), .op_done(op_done), .op_timeout(op_timeout), .busy(busy), .locked(locked)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask
  // expectations are kept per cycle: an accepted request schedules its answer two cycles ahead
  always @(negedge clk) begin
    mn = cyc;
    mhit = 0;
    if (!rst_n) begin
      for (int k = mn; k < N; k++) begin
        e_busy[k] = 0; e_lock[k] = 0; e_done[k] = 0; e_fail[k] = 0; e_to[k] = 0; e_opc[k] = 0; e_dat[k] = 0;
      end
      for (int i = 0; i < 4; i++) m_vld[i] = 0;
      fails = 0;
      win_act = 0;
    end else if (op_done && win_act && mn > win_g && mn <= win_g + TO) begin
      for (int k = mn + 1; k <= win_g + TO; k++) e_busy[k] = 0;
      e_to[win_g + TO] = 0;
      win_act = 0;
    end
    chk("auth_done", auth_done, e_done[mn]);
    chk("op_start", op_start, e_done[mn]);
    chk("auth_fail", auth_fail, e_fail[mn]);
    chk("op_timeout", op_timeout, e_to[mn]);
    chk("busy", busy, e_busy[mn]);
    chk("locked", locked, e_lock[mn]);
    chk("op_code", op_code, e_opc[mn]);
    chk("data", data, e_dat[mn]);
    if (rst_n) begin
      if (cfg_we) begin
        m_id[cfg_idx] = cfg_id;
        m_vld[cfg_idx] = cfg_valid;
      end
      if (e_lock[mn] && unlock) begin
        for (int k = mn + 1; k < N; k++) e_lock[k] = 0;
        fails = 0;
      end else if (e_lock[mn] && start) e_fail[mn + 2] = 1;
      else if (!e_lock[mn] && !e_busy[mn] && start) begin
        for (int i = 0; i < 4; i++) mhit = mhit | (m_vld[i] && m_id[i] == frame[15:9]);
        if (mhit) begin
          for (int k = mn + 1; k <= mn + 2 + TO; k++) e_busy[k] = 1;
          for (int k = mn + 2; k < N; k++) begin
            e_opc[k] = frame[8:7];
            e_dat[k] = {1'b0, frame[6:0]};
          end
          e_done[mn + 2] = 1;
          e_to[mn + 2 + TO] = 1;
          win_g = mn + 2;
          win_act = 1;
          fails = 0;
        end else begin
          e_busy[mn + 1] = 1;
          e_busy[mn + 2] = 1;
          e_fail[mn + 2] = 1;
          fails++;
          if (fails == 3) for (int k = mn + 3; k < N; k++) e_lock[k] = 1;
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic cfg(input logic [1:0] i, input logic [6:0] id, input logic v);
    cfg_we = 1; cfg_idx = i; cfg_id = id; cfg_valid = v;
    tick();
    cfg_we = 0;
  endtask
  task automatic req(input logic [15:0] f);
    start = 1; frame = f;
    tick();
    start = 0;
  endtask
  task automatic grant_chk(input logic [15:0] f, input logic [1:0] opc, input logic [7:0] d);
    req(f);
    tick();
    @(negedge clk);
    chk("lit_grant", auth_done, 1);
    chk("lit_dispatch", op_start, 1);
    chk("lit_op_code", op_code, opc);
    chk("lit_data", data, d);
  endtask
  task automatic deny_once(input logic [15:0] f);
    req(f);
    tick();
    @(negedge clk);
    chk("lit_deny", auth_fail, 1);
    chk("lit_no_grant", auth_done, 0);
    tick();
  endtask
  initial begin
    repeat (3) tick();
    @(negedge clk);
    chk("lit_rst_busy", busy, 0);
    chk("lit_rst_locked", locked, 0);
    tick();
    rst_n = 1;
    tick();
    cfg(0, 7'h2A, 1);
    grant_chk(16'h5523, 2'd2, 8'h23);
    repeat (5) tick();
    op_done = 1;
    tick();
    op_done = 0;
    @(negedge clk);
    chk("lit_done_idle", busy, 0);
    tick();
    cfg(0, 7'h2A, 0);
    repeat (3) deny_once(16'h2200);
    @(negedge clk);
    chk("lit_lockout", locked, 1);
    tick();
    cfg(0, 7'h2A, 1);
    req(16'h5523);
    tick();
    @(negedge clk);
    chk("lit_locked_fail", auth_fail, 1);
    chk("lit_locked_nodisp", op_start, 0);
    chk("lit_still_locked", locked, 1);
    tick();
    start = 1; unlock = 1; frame = 16'h5523;
    tick();
    start = 0; unlock = 0;
    tick();
    @(negedge clk);
    chk("lit_unlock_wins", auth_fail, 0);
    chk("lit_unlocked", locked, 0);
    tick();
    grant_chk(16'h5523, 2'd2, 8'h23);
    repeat (TO) tick();
    @(negedge clk);
    chk("lit_timeout", op_timeout, 1);
    tick();
    @(negedge clk);
    chk("lit_to_idle", busy, 0);
    tick();
    grant_chk(16'h54FF, 2'd1, 8'h7F);
    repeat (TO) tick();
    op_done = 1;
    @(negedge clk);
    chk("lit_done_beats_to", op_timeout, 0);
    tick();
    op_done = 0;
    @(negedge clk);
    chk("lit_done8_idle", busy, 0);
    tick();
    repeat (2) deny_once(16'h2200);
    grant_chk(16'h5523, 2'd2, 8'h23);
    tick();
    req(16'h2200);
    tick();
    op_done = 1;
    @(negedge clk);
    chk("lit_drop_start", auth_fail, 0);
    tick();
    op_done = 0;
    repeat (2) deny_once(16'h2200);
    @(negedge clk);
    chk("lit_cleared_cnt", locked, 0);
    tick();
    deny_once(16'h2200);
    @(negedge clk);
    chk("lit_relock", locked, 1);
    tick();
    unlock = 1;
    tick();
    unlock = 0;
    grant_chk(16'h5523, 2'd2, 8'h23);
    tick();
    tick();
    rst_n = 0;
    @(negedge clk);
    chk("lit_arst_busy", busy, 0);
    chk("lit_arst_opc", op_code, 0);
    chk("lit_arst_data", data, 0);
    tick();
    rst_n = 1;
    tick();
    op_done = 1;
    tick();
    op_done = 0;
    @(negedge clk);
    chk("lit_stale_done", busy, 0);
    tick();
    start = 1; frame = 16'h5523;
    tick();
    start = 0;
    cfg(0, 7'h2A, 1);
    @(negedge clk);
    chk("lit_check_write_unseen", auth_fail, 1);
    chk("lit_check_write_nogrant", auth_done, 0);
    tick();
    cfg(1, 7'h2A, 1);
    grant_chk(16'h5401, 2'd0, 8'h01);
    repeat (3) tick();
    op_done = 1;
    tick();
    op_done = 0;
    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/server_auth_responder.md
# server_auth_responder

Server-side responder for the user request protocol, in the server clock domain, after the user→server start synchronizer. It captures a 16-bit request frame on a start pulse and checks the requester ID against a loadable table of authorized IDs. It answers with a one-cycle auth_done or auth_fail pulse and, on grant, dispatches one operation to the operation unit. It then waits for the synchronized completion pulse, which is guarded by a timeout and a consecutive-failure lockout.

## Interface
- NUM_IDS, 4: authorized-ID table entries (power of two, 2..16).
- MAX_FAILS, 3: consecutive denied requests that cause lockout (1..15).
- OP_TIMEOUT, 255: cycles to wait for op_done before abandoning (1..65535).
- clk  in  1  server clock; single clock domain.
- rst_n  in  1  reset; asynchronous, active-low.
- cfg_we  in  1  write one table entry this cycle.
- cfg_idx  in  $clog2(NUM_IDS)  entry index.
- cfg_id  in  7  ID written to the entry.
- cfg_valid  in  1  entry valid bit written with cfg_id; 0 disables the entry.
- unlock  in  1  pulse that clears lockout; ignored outside LOCKED.
- start  in  1  one-cycle request pulse, already synchronized.
- frame  in  16  request: [15:9] ID, [8:7] op_code, [6:0] data; sampled only with start.
- auth_done  out  1  one-cycle grant pulse.
- auth_fail  out  1  one-cycle deny pulse.
- op_start  out  1  one-cycle dispatch pulse to the operation unit.
- op_code  out  2  registered op code.
- data  out  8  registered operand, {1'b0, frame[6:0]}.
- op_done  in  1  one-cycle completion pulse, already synchronized.
- op_timeout  out  1  one-cycle pulse on abandoned operation.
- busy  out  1  high in every state except IDLE and LOCKED.
- locked  out  1  high in LOCKED.

## Operation
- Reset values: all outputs 0, table entries invalid, fail counter 0, timeout counter 0, state IDLE.
- States: IDLE, CHECK, GRANT, WAIT_OP, DENY, LOCKED.
- IDLE: start=1 captures frame → CHECK.
- CHECK: compares the captured ID with every valid entry.
  - Any match → GRANT.
  - No match → DENY.
- GRANT (one cycle): auth_done=1 and op_start=1; op_code and data are loaded and held until the next grant; fail counter cleared → WAIT_OP.
- WAIT_OP: op_done=1 → IDLE.
  - The timeout counter reaching OP_TIMEOUT cycles without op_done pulses op_timeout → IDLE.
  - Counting starts at 1 in the first WAIT_OP cycle.
- DENY (one cycle): auth_fail=1; fail counter +1.
  - If the new count equals MAX_FAILS → LOCKED.
  - Otherwise → IDLE.
- LOCKED: each start is answered with an auth_fail pulse 2 cycles later and is never checked or dispatched; the fail counter saturates.
  - unlock=1 clears the counter → IDLE. unlock wins if start arrives in the same cycle.
- Table write: takes effect the cycle after cfg_we. A write in the CHECK cycle is not seen by that comparison. Writes are accepted in any state.
- Duplicate IDs in the table are legal; any match grants.

## Timing
- Request latency: start at cycle 0 → auth_done/auth_fail and op_start at cycle 2. The grant and the dispatch are simultaneous.
- Back-to-back: the earliest next accepted start is the cycle the state returns to IDLE. After a deny that is cycle 3.
- start outside IDLE/LOCKED is dropped silently; no response.
- op_done outside WAIT_OP is ignored.
- op_done in the same cycle the timeout expires: op_done wins, with no op_timeout pulse.
- auth_done, auth_fail, op_start and op_timeout are never high for more than one cycle. auth_done and auth_fail are never high together.
- Reset mid-operation: immediate return to the reset values. A pending operation is forgotten, and a later op_done is ignored.

## Test plan
- Load entry 0 = 7'h2A valid; start with frame 16'h5523 (ID 2A, op 2, data 23) → cycle 2: auth_done=1, op_start=1, op_code=2, data=8'h23. op_done 10 cycles later → IDLE, busy=0.
- Empty table, start with ID 7'h11 → auth_fail at cycle 2, no op_start. Repeat twice more (MAX_FAILS=3) → locked=1.
- While locked, start with authorized ID 2A → auth_fail only, locked stays 1. unlock → IDLE; start with ID 2A → grant.
- Grant with OP_TIMEOUT=8 and no op_done → op_timeout pulse 8 cycles after GRANT, then IDLE. op_done exactly on the 8th cycle → no op_timeout.
- Two denies, then a grant, then two denies → not locked, because the grant cleared the counter. A start during WAIT_OP → no response.
- Assert rst_n=0 in WAIT_OP → all outputs 0 at once. After release, op_done → no effect.
